button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 195 +++++++++++++++++++
 tb/tb_button_debounce.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//
// Conditioning stage for a raw active-low pushbutton. The button is brought
// into the clk domain through a two-flop synchroniser, debounced by requiring
// DEBOUNCE_CYCLES consecutive stable samples, and each accepted press is then
// classified as short or long (held for LONG_CYCLES).
//
// Ports
//   clk           : system clock, all logic on posedge
//   rst           : asynchronous active-low reset
//   btn_n         : raw pushbutton, 0 = pressed, asynchronous and bouncy
//   btn_level     : debounced level, 1 = pressed
//   press_pulse   : one-cycle pulse on confirmed press
//   release_pulse : one-cycle pulse on confirmed release
//   long_pulse    : one-cycle pulse when the hold reaches LONG_CYCLES
//   toggle_state  : flips on each short press at release, cleared by a long
//                   press
// ----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int LONG_CYCLES     = 4000000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic toggle_state
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic             r_long_seen;
    logic             w_long_seen_nxt;
    logic             r_btn_level;
    logic             w_btn_level_nxt;
    logic             r_press_pulse;
    logic             w_press_pulse_nxt;
    logic             r_release_pulse;
    logic             w_release_pulse_nxt;
    logic             r_long_pulse;
    logic             w_long_pulse_nxt;
    logic             r_toggle_state;
    logic             w_toggle_state_nxt;

    // Two-flop synchroniser; idles at 1 (button released).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_dcnt          <= CNT_ZERO;
            r_hcnt          <= CNT_ZERO;
            r_long_seen     <= 1'b0;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_toggle_state  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_dcnt          <= w_dcnt_nxt;
            r_hcnt          <= w_hcnt_nxt;
            r_long_seen     <= w_long_seen_nxt;
            r_btn_level     <= w_btn_level_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_long_pulse    <= w_long_pulse_nxt;
            r_toggle_state  <= w_toggle_state_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        w_state_nxt         = r_state;
        w_dcnt_nxt          = r_dcnt;
        w_hcnt_nxt          = r_hcnt;
        w_long_seen_nxt     = r_long_seen;
        w_btn_level_nxt     = r_btn_level;
        w_press_pulse_nxt   = 1'b0;
        w_release_pulse_nxt = 1'b0;
        w_long_pulse_nxt    = 1'b0;
        w_toggle_state_nxt  = r_toggle_state;

        case (r_state)
            ST_IDLE: begin
                // The sample that triggers the transition is itself the first
                // stable sample, so the count starts at one. This makes the
                // press confirm DEBOUNCE_CYCLES samples after s first goes low.
                if (!w_s) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_dcnt_nxt  = CNT_ONE;
                end else begin
                    w_dcnt_nxt  = CNT_ZERO;
                end
            end

            ST_PRESS_WAIT: begin
                if (w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_dcnt_nxt  = CNT_ZERO;
                end else if (r_dcnt == DEB_LAST) begin
                    w_state_nxt       = ST_PRESSED;
                    w_btn_level_nxt   = 1'b1;
                    w_press_pulse_nxt = 1'b1;
                    w_hcnt_nxt        = CNT_ZERO;
                    w_long_seen_nxt   = 1'b0;
                end else begin
                    w_dcnt_nxt = r_dcnt + CNT_ONE;
                end
            end

            ST_PRESSED: begin
                if (w_s) begin
                    // Same first-sample counting as on the press side keeps
                    // release latency symmetric. hcnt is left frozen.
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_dcnt_nxt  = CNT_ONE;
                end else if ((r_hcnt == LONG_LAST) && !r_long_seen) begin
                    w_long_pulse_nxt   = 1'b1;
                    w_long_seen_nxt    = 1'b1;
                    w_toggle_state_nxt = 1'b0;
                end else if (r_hcnt < LONG_LAST) begin
                    w_hcnt_nxt = r_hcnt + CNT_ONE;
                end else begin
                    w_hcnt_nxt = r_hcnt;
                end
            end

            ST_RELEASE_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_dcnt == DEB_LAST) begin
                    w_state_nxt         = ST_IDLE;
                    w_btn_level_nxt     = 1'b0;
                    w_release_pulse_nxt = 1'b1;
                    if (!r_long_seen) begin
                        w_toggle_state_nxt = ~r_toggle_state;
                    end else begin
                        w_toggle_state_nxt = r_toggle_state;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_dcnt_nxt  = CNT_ZERO;
            end
        endcase
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign toggle_state  = r_toggle_state;

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Edges are numbered from 1 at the first posedge after btn_n changes; outputs
// are sampled 1 time unit after each posedge and compared as the vector
// {btn_level, press_pulse, release_pulse, long_pulse, toggle_state}.
// ----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic clk;
    logic rst;
    logic btn_n;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic toggle_state;

    int n_vec;
    int n_err;

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .CNT_W           (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .toggle_state  (toggle_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {btn_level, press_pulse, release_pulse, long_pulse, toggle_state};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst   = 1'b0;
        btn_n = 1'b1;
        #2;
        obs = outs();
        n_vec++;
        if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_async got=%b exp=%b", obs, 5'b00000);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            obs = outs();
            n_vec++;
            if (obs !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_idle e=%0d got=%b exp=%b", e, obs, 5'b00000);
            end
        end
    endtask

    // Press held cleanly, then released cleanly; tog is the toggle before.
    task automatic test_clean_press(input logic tog, input int hold, input string nm);
        logic [4:0] obs;
        logic [4:0] exp;
        btn_n = 1'b0;
        for (int e = 1; e <= hold; e++) begin
            tick();
            exp = {(e >= D + 2), (e == D + 2), 1'b0, 1'b0, tog};
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s_press e=%0d got=%b exp=%b", nm, e, obs, exp);
            end
        end
        btn_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {(e < D + 2), 1'b0, (e == D + 2), 1'b0,
                   ((e >= D + 2) ? ~tog : tog)};
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s_release e=%0d got=%b exp=%b", nm, e, obs, exp);
            end
        end
    endtask

    // Two bursts of three low samples: never enough to confirm a press.
    task automatic test_bounce(input logic tog);
        logic [4:0] obs;
        logic [4:0] exp;
        logic [13:0] pat;
        pat = 14'b1111_1000_1000_11;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, tog};
        for (int e = 1; e <= 14; e++) begin
            btn_n = pat[14 - e];
            tick();
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bounce e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
    endtask

    // Hold 40 cycles from toggle_state=1: single long_pulse 20 after press.
    task automatic test_long_press();
        logic [4:0] obs;
        logic [4:0] exp;
        btn_n = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp = {(e >= D + 2), (e == D + 2), 1'b0, (e == D + 2 + L),
                   (e < D + 2 + L)};
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL long_hold e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
        btn_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {(e < D + 2), 1'b0, (e == D + 2), 1'b0, 1'b0};
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL long_release e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
    endtask

    // Two high samples in PRESSED: no release, long_pulse 3 cycles later
    // (two frozen cycles plus the cycle returning to PRESSED).
    task automatic test_release_bounce();
        logic [4:0] obs;
        logic [4:0] exp;
        for (int e = 1; e <= 36; e++) begin
            btn_n = (e == 11 || e == 12) ? 1'b1 : 1'b0;
            tick();
            exp = {(e >= D + 2), (e == D + 2), 1'b0, (e == D + 2 + L + 3), 1'b0};
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rel_bounce e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
        btn_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = {(e < D + 2), 1'b0, (e == D + 2), 1'b0, 1'b0};
            obs = outs();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rel_bounce_release e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
    endtask

    // Reset during PRESS_WAIT, and during PRESSED with toggle_state=1.
    task automatic test_reset_mid();
        logic [4:0] obs;
        logic [4:0] exp;
        for (int pass = 0; pass < 2; pass++) begin
            btn_n = 1'b0;
            for (int e = 1; e <= ((pass == 0) ? 4 : 8); e++) begin
                tick();
            end
            if (pass == 1) begin
                obs = outs();
                n_vec++;
                if (obs !== 5'b10001) begin
                    n_err++;
                    $display("FAIL mid_pre_reset got=%b exp=%b", obs, 5'b10001);
                end
            end
            rst = 1'b0;
            #2;
            obs = outs();
            n_vec++;
            if (obs !== 5'b00000) begin
                n_err++;
                $display("FAIL mid_reset_async pass=%0d got=%b exp=%b", pass, obs, 5'b00000);
            end
            tick();
            rst = 1'b1;
            for (int e = 1; e <= 8; e++) begin
                tick();
                exp = {(e >= D + 2), (e == D + 2), 1'b0, 1'b0, 1'b0};
                obs = outs();
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL mid_repress pass=%0d e=%0d got=%b exp=%b", pass, e, obs, exp);
                end
            end
            if (pass == 0) begin
                // Short release here brings toggle_state to 1 for pass 1.
                btn_n = 1'b1;
                for (int e = 1; e <= 10; e++) begin
                    tick();
                end
                obs = outs();
                n_vec++;
                if (obs !== 5'b00001) begin
                    n_err++;
                    $display("FAIL mid_toggle_set got=%b exp=%b", obs, 5'b00001);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        btn_n = 1'b1;
        test_reset();
        test_clean_press(1'b0, 10, "clean");    // toggle 0 -> 1
        test_bounce(1'b1);
        test_clean_press(1'b1, 10, "short1");   // toggle 1 -> 0
        test_clean_press(1'b0, 10, "short2");   // toggle 0 -> 1
        test_long_press();                      // toggle 1 -> 0 at long
        test_release_bounce();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
